// File: rtl/tpu_result_drain.sv
// tpu_result_drain
// Captures result rows from the three tpu_top write ports (banks a/b/c) into
// one-row holding registers. Each row is serialized onto a single
// valid/ready stream as one header word followed by NWORDS data words.
//
// Ports:
//   clk, srstn                 clock, asynchronous active-low reset
//   tpu_start                  job start pulse; clears overflow/done status
//   tpu_done                   tpu_top has issued its last write
//   sram_write_enable_{a,b,c}0 row write strobes
//   sram_wdata_{a,b,c}         row data (ARRAY_SIZE*OUTPUT_DATA_WIDTH bits)
//   sram_waddr_{a,b,c}         row address (6 bits)
//   m_valid/m_ready/m_data     output stream
//   m_last                     final word of the current row
//   overflow                   sticky row-drop flags {c,b,a}
//   drain_done                 every row of the job has been emitted
//
// Build option: define ROW_CHECKSUM_EN to append an XOR checksum word to
// every row. m_last then marks the checksum word instead of the last data word.
module tpu_result_drain #(
  parameter int ARRAY_SIZE        = 32,
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int OUT_WIDTH         = 32
) (
  input  logic                                  clk,
  input  logic                                  srstn,
  input  logic                                  tpu_start,
  input  logic                                  tpu_done,
  input  logic                                  sram_write_enable_a0,
  input  logic                                  sram_write_enable_b0,
  input  logic                                  sram_write_enable_c0,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_wdata_a,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_wdata_b,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_wdata_c,
  input  logic [5:0]                            sram_waddr_a,
  input  logic [5:0]                            sram_waddr_b,
  input  logic [5:0]                            sram_waddr_c,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [OUT_WIDTH-1:0]                  m_data,
  output logic                                  m_last,
  output logic [2:0]                            overflow,
  output logic                                  drain_done
);

  localparam int ROW_W  = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
  localparam int NWORDS = ROW_W / OUT_WIDTH;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

`ifdef ROW_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_CSUM} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;
`endif

  state_t r_state, w_state_nxt;

  // Holding registers, one row per bank
  logic [ROW_W-1:0] r_hold_data [3];
  logic [5:0]       r_hold_addr [3];
  logic [2:0]       r_full;

  // Row currently being serialized
  logic [ROW_W-1:0] r_row;
  logic [1:0]       r_bank;
  logic [5:0]       r_addr;
  logic [CNT_W-1:0] r_widx;
`ifdef ROW_CHECKSUM_EN
  logic [OUT_WIDTH-1:0] r_csum;
`endif

  logic [2:0] r_overflow;
  logic       r_done_seen;
  logic       r_drain_done;

  logic [2:0]       w_we;
  logic [ROW_W-1:0] w_wdata [3];
  logic [5:0]       w_waddr [3];
  logic             w_accept;
  logic             w_any_full;
  logic [1:0]       w_sel;
  logic             w_load;
  logic [2:0]       w_unload;
  logic [2:0]       w_capture;
  logic [2:0]       w_drop;
  logic             w_last_word;
  logic [31:0]      w_hdr;

  assign w_we       = {sram_write_enable_c0, sram_write_enable_b0, sram_write_enable_a0};
  assign w_wdata[0] = sram_wdata_a;
  assign w_wdata[1] = sram_wdata_b;
  assign w_wdata[2] = sram_wdata_c;
  assign w_waddr[0] = sram_waddr_a;
  assign w_waddr[1] = sram_waddr_b;
  assign w_waddr[2] = sram_waddr_c;

  assign w_accept    = m_valid & m_ready;
  assign w_any_full  = |r_full;
  assign w_sel       = r_full[0] ? 2'd0 : (r_full[1] ? 2'd1 : 2'd2);
  assign w_last_word = (r_widx == CNT_W'(NWORDS - 1));
  assign w_hdr       = {8'hA5, 14'b0, r_bank, 2'b0, r_addr};

  // A bank being unloaded this cycle frees its slot for a simultaneous strobe
  assign w_unload  = w_load ? (3'b001 << w_sel) : 3'b000;
  assign w_capture = w_we & (~r_full | w_unload);
  assign w_drop    = w_we & r_full & ~w_unload;

  assign overflow   = r_overflow;
  assign drain_done = r_drain_done;

  // Next-state and stream outputs; outputs depend only on registered state,
  // so they stay frozen while the sink stalls.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    m_valid     = 1'b0;
    m_data      = '0;
    m_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_full) begin
          w_load      = 1'b1;
          w_state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        m_valid = 1'b1;
        m_data  = OUT_WIDTH'(w_hdr);
        if (m_ready) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        m_valid = 1'b1;
        m_data  = r_row[OUT_WIDTH-1:0];
`ifdef ROW_CHECKSUM_EN
        if (w_accept && w_last_word) w_state_nxt = S_CSUM;
`else
        m_last = w_last_word;
        if (w_accept && w_last_word) begin
          if (w_any_full) begin
            w_load      = 1'b1;
            w_state_nxt = S_HDR;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
`endif
      end
`ifdef ROW_CHECKSUM_EN
      S_CSUM: begin
        m_valid = 1'b1;
        m_data  = r_csum;
        m_last  = 1'b1;
        if (m_ready) begin
          if (w_any_full) begin
            w_load      = 1'b1;
            w_state_nxt = S_HDR;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control state
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      r_state      <= S_IDLE;
      r_full       <= 3'b000;
      r_widx       <= '0;
      r_overflow   <= 3'b000;
      r_done_seen  <= 1'b0;
      r_drain_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_full  <= (r_full & ~w_unload) | w_capture;

      if (w_load) begin
        r_widx <= '0;
      end else if (r_state == S_DATA && w_accept) begin
        r_widx <= r_widx + 1'b1;
      end

      // A new job clears the sticky status, even against a same-cycle drop
      if (tpu_start) begin
        r_overflow   <= 3'b000;
        r_done_seen  <= 1'b0;
        r_drain_done <= 1'b0;
      end else begin
        r_overflow <= r_overflow | w_drop;
        if (tpu_done) r_done_seen <= 1'b1;
        if (r_done_seen && !w_any_full && r_state == S_IDLE) r_drain_done <= 1'b1;
      end
    end
  end

  // Datapath registers; validity is tracked by r_full / r_state
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (w_capture[i]) begin
        r_hold_data[i] <= w_wdata[i];
        r_hold_addr[i] <= w_waddr[i];
      end
    end
    if (w_load) begin
      r_row  <= r_hold_data[w_sel];
      r_addr <= r_hold_addr[w_sel];
      r_bank <= w_sel;
`ifdef ROW_CHECKSUM_EN
      r_csum <= '0;
`endif
    end else if (r_state == S_DATA && w_accept) begin
      r_row <= r_row >> OUT_WIDTH;
`ifdef ROW_CHECKSUM_EN
      r_csum <= r_csum ^ r_row[OUT_WIDTH-1:0];
`endif
    end
  end

endmodule
